// File: rtl/div_unit_pkg.sv
// Shared CPU definitions for the E-stage iterative divider.
package cpu_defines;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div_step
    import cpu_defines::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // One extra bit: the shifted partial remainder can reach 2*divisor-1.
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;

    assign rem_shift = {rem, quo[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, divisor};

    always_comb begin
        quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
        if (trial[WIDTH]) begin
            rem_next = rem_shift[WIDTH-1:0];
        end else begin
            rem_next = trial[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU in the E stage; stalls the pipe
// while busy and holds hi/lo until the instruction advances.
//
// state | meaning
// IDLE  | waiting for a DIV/DIVU in E; operands sampled on start
// BUSY  | one quotient bit per cycle, WIDTH cycles
// DONE  | hi/lo valid, held until advance or flush
module div_unit
    import cpu_defines::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic             flush,
    input  logic             advance,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             div_stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] divisor_q;
    logic             q_neg;
    logic             r_neg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_step;

    assign a_mag     = (signed_div && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_div && b[WIDTH-1]) ? -b : b;
    assign last_step = (cnt == CNT_W'(WIDTH-1));

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (divisor_q),
        .rem_next(rem_next),
        .quo_next(quo_next)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        quo_q     <= a_mag;
                        divisor_q <= b_mag;
                        q_neg     <= (a[WIDTH-1] ^ b[WIDTH-1]) & signed_div;
                        r_neg     <= a[WIDTH-1] & signed_div;
                        rem_q     <= '0;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt   <= cnt + CNT_W'(1);
                        if (last_step) begin
                            lo    <= q_neg ? -quo_next : quo_next;
                            hi    <= r_neg ? -rem_next : rem_next;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Stays put while other stall sources hold the pipe.
                    if (advance || flush) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign result_valid = (state == DONE);

    // Gated by resetn so the stall drops immediately during an async reset.
    assign div_stall = resetn &
                       (((state == IDLE) && start && !flush) ||
                        ((state == BUSY) && !flush));

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a queue-based scoreboard and monitor.
module tb_div_unit;
    import cpu_defines::*;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic        flush;
    logic        advance;
    logic [31:0] a;
    logic [31:0] b;
    logic        div_stall;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [31:0] s_rem, s_quo, s_div, s_rem_n, s_quo_n;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    chk_t        chk_q[$];
    logic [63:0] exp_q[$];
    int          n_tests;
    int          n_fail;
    logic        rv_prev;

    div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .signed_div  (signed_div),
        .flush       (flush),
        .advance     (advance),
        .a           (a),
        .b           (b),
        .div_stall   (div_stall),
        .result_valid(result_valid),
        .hi          (hi),
        .lo          (lo)
    );

    div_step #(.WIDTH(32)) u_step (
        .rem     (s_rem),
        .quo     (s_quo),
        .divisor (s_div),
        .rem_next(s_rem_n),
        .quo_next(s_quo_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected summary before 50000");
        $fatal(1);
    end

    // Monitor: drains directed checks and compares hi/lo on each new result.
    initial begin
        chk_t        c;
        logic [63:0] e;
        n_tests = 0;
        n_fail  = 0;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                n_tests++;
                if (c.act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", c.name, c.act, c.exp);
                end
            end
            if (result_valid === 1'b1 && rv_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got hi=%h lo=%h, expected no result", hi, lo);
                end else begin
                    e = exp_q.pop_front();
                    n_tests++;
                    if (lo !== e[31:0]) begin
                        n_fail++;
                        $display("FAIL result_lo: got %h, expected %h", lo, e[31:0]);
                    end
                    n_tests++;
                    if (hi !== e[63:32]) begin
                        n_fail++;
                        $display("FAIL result_hi: got %h, expected %h", hi, e[63:32]);
                    end
                end
            end
            rv_prev = result_valid;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_vec(input logic [31:0] r, q, d, er, eq);
        s_rem = r;
        s_quo = q;
        s_div = d;
        #1;
        check("step_rem", s_rem_n, er);
        check("step_quo", s_quo_n, eq);
    endtask

    task automatic run_div(input logic sd, input logic [31:0] av, bv, ehi, elo, input int hold);
        int cnt;
        cnt        = 0;
        a          = av;
        b          = bv;
        signed_div = sd;
        start      = 1'b1;
        advance    = 1'b0;
        flush      = 1'b0;
        exp_q.push_back({ehi, elo});
        #1;
        while (div_stall === 1'b1 && cnt < 60) begin
            cnt++;
            step();
        end
        check("stall_len", 32'(cnt), 32'd33);
        check("done_valid", {31'b0, result_valid}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            a = ~av;
            b = ~bv;
            step();
            check("hold_stall", {31'b0, div_stall}, 32'd0);
            check("hold_valid", {31'b0, result_valid}, 32'd1);
            check("hold_hi", hi, ehi);
            check("hold_lo", lo, elo);
        end
        advance = 1'b1;
        step();
        start   = 1'b0;
        advance = 1'b0;
        #1;
        check("idle_valid", {31'b0, result_valid}, 32'd0);
    endtask

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        flush      = 1'b0;
        advance    = 1'b0;
        a          = '0;
        b          = '0;
        s_rem      = '0;
        s_quo      = '0;
        s_div      = '0;
        #3;
        check("reset_stall", {31'b0, div_stall}, 32'd0);
        check("reset_valid", {31'b0, result_valid}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        step_vec(32'd0, 32'h8000_0000, 32'd1, 32'd0, 32'd1);
        step_vec(32'd3, 32'd0, 32'd5, 32'd1, 32'd1);
        step_vec(32'd2, 32'd0, 32'd5, 32'd4, 32'd0);
        step_vec(32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd1);

        #6;
        resetn = 1'b1;
        step();

        run_div(1'b0, 32'd7, 32'd2, 32'd1, 32'd3, 0);

        // Flush ten cycles into BUSY; previous hi/lo must survive.
        a          = 32'd100;
        b          = 32'd7;
        signed_div = 1'b0;
        start      = 1'b1;
        #1;
        step();
        repeat (10) step();
        flush = 1'b1;
        #1;
        check("flush_stall", {31'b0, div_stall}, 32'd0);
        step();
        check("flush_valid", {31'b0, result_valid}, 32'd0);
        check("flush_idle_stall", {31'b0, div_stall}, 32'd0);
        check("flush_hi", hi, 32'd1);
        check("flush_lo", lo, 32'd3);
        run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 0);

        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 4);
        run_div(1'b0, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 0);
        run_div(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 0);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);

        // Async reset twenty cycles into BUSY with start still high.
        a          = 32'hFFFF_FF9C;
        b          = 32'd7;
        signed_div = 1'b1;
        start      = 1'b1;
        #1;
        step();
        repeat (20) step();
        #2;
        resetn = 1'b0;
        #1;
        check("arst_stall", {31'b0, div_stall}, 32'd0);
        check("arst_valid", {31'b0, result_valid}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        #2;
        resetn = 1'b1;
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
